// File: rtl/borrow_bypass_subtractor_pipe_pkg.sv
// Shared ALU definitions: default operand geometry and the result record
// used by the adder/subtractor consumers.
package borrow_bypass_subtractor_pipe_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_GROUP_W = 4;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] diff;
    logic                     bout;
    logic                     overflow;
  } result_t;

endpackage

// File: rtl/borrow_bypass_subtractor_pipe_group.sv
// One borrow-bypass group: bitwise ripple borrow plus a mux that forwards the
// incoming borrow straight through when every bit pair is equal.
module borrow_bypass_group
  import borrow_bypass_subtractor_pipe_pkg::*;
#(
  parameter int GROUP_W = DEFAULT_GROUP_W
) (
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               bin,
  output logic [GROUP_W-1:0] diff,
  output logic               bout
);

  logic [GROUP_W:0] br;
  logic             propagate;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    br    = '0;
    diff  = '0;
    br[0] = bin;
    for (int i = 0; i < GROUP_W; i++) begin
      diff[i]  = a[i] ^ b[i] ^ br[i];
      br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
    // Equal bit pairs pass the borrow unchanged, so the group can skip its ripple.
    propagate = &(~(a ^ b));
    bout      = propagate ? bin : br[GROUP_W];
  end

endmodule

// File: rtl/borrow_bypass_subtractor_pipe.sv
// Two-stage valid/ready pipelined subtractor: diff = a - b - bin. The low half
// and the mid borrow are registered in stage 1, the high half finishes in stage 2.
module borrow_bypass_subtractor_pipe
  import borrow_bypass_subtractor_pipe_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int GROUP_W = DEFAULT_GROUP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int HALF = WIDTH / 2;
  localparam int NG   = HALF / GROUP_W;

  // Stage 1 registers
  logic            s1_valid;
  logic [HALF-1:0] s1_diff_lo;
  logic            s1_mid_br;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_b_hi;

  // Stage 2 registers
  logic             s2_valid;
  logic [WIDTH-1:0] s2_diff;
  logic             s2_bout;
  logic             s2_ovf;

  logic            s2_load;
  logic [HALF-1:0] lo_diff;
  logic [HALF-1:0] hi_diff;
  logic            mid_br;
  logic            hi_bout;
  logic            hi_ovf;

  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // Low-half borrow chain; each group's borrow lives in its own generate scope.
  for (genvar g = 0; g < NG; g++) begin : g_lo
    logic br_in;
    logic br_out;
    if (g == 0) begin : g_first
      assign br_in = bin;
    end else begin : g_next
      assign br_in = g_lo[g-1].br_out;
    end
    borrow_bypass_group #(.GROUP_W(GROUP_W)) u_grp (
      .a    (a[g*GROUP_W +: GROUP_W]),
      .b    (b[g*GROUP_W +: GROUP_W]),
      .bin  (br_in),
      .diff (lo_diff[g*GROUP_W +: GROUP_W]),
      .bout (br_out)
    );
  end

  assign mid_br = g_lo[NG-1].br_out;

  // High-half borrow chain, fed from the registered operands and mid borrow.
  for (genvar g = 0; g < NG; g++) begin : g_hi
    logic br_in;
    logic br_out;
    if (g == 0) begin : g_first
      assign br_in = s1_mid_br;
    end else begin : g_next
      assign br_in = g_hi[g-1].br_out;
    end
    borrow_bypass_group #(.GROUP_W(GROUP_W)) u_grp (
      .a    (s1_a_hi[g*GROUP_W +: GROUP_W]),
      .b    (s1_b_hi[g*GROUP_W +: GROUP_W]),
      .bin  (br_in),
      .diff (hi_diff[g*GROUP_W +: GROUP_W]),
      .bout (br_out)
    );
  end

  assign hi_bout = g_hi[NG-1].br_out;
  assign hi_ovf  = (s1_a_hi[HALF-1] != s1_b_hi[HALF-1]) &&
                   (hi_diff[HALF-1] != s1_a_hi[HALF-1]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the data registers are cleared on reset because
  // the outputs must read zero right after it, not merely be marked invalid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_diff_lo <= '0;
      s1_mid_br  <= 1'b0;
      s1_a_hi    <= '0;
      s1_b_hi    <= '0;
      s2_valid   <= 1'b0;
      s2_diff    <= '0;
      s2_bout    <= 1'b0;
      s2_ovf     <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_diff <= {hi_diff, s1_diff_lo};
          s2_bout <= hi_bout;
          s2_ovf  <= hi_ovf;
        end
      end
      // Stage 1 is free whenever it is empty or its content moves on this edge.
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_diff_lo <= lo_diff;
          s1_mid_br  <= mid_br;
          s1_a_hi    <= a[WIDTH-1:HALF];
          s1_b_hi    <= b[WIDTH-1:HALF];
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign diff      = s2_diff;
  assign bout      = s2_bout;
  assign overflow  = s2_ovf;

endmodule

// File: tb/tb_borrow_bypass_subtractor_pipe.sv
// Directed plus randomized bench for the pipelined subtractor, checked against
// an arithmetic reference model and an in-order expected-result queue.
module tb_borrow_bypass_subtractor_pipe;
  import borrow_bypass_subtractor_pipe_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;

  int      n_cmp = 0;
  int      n_err = 0;
  int      n_consumed = 0;
  result_t exp_q[$];
  logic    last_acc;
  logic    last_in_ready;

  borrow_bypass_subtractor_pipe #(.WIDTH(W), .GROUP_W(DEFAULT_GROUP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned and signed arithmetic, no bit-level borrow logic.
  function automatic result_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                    input logic bv_in);
    result_t     r;
    logic [W:0]  u;
    longint      s;
    u = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bv_in};
    s = longint'($signed(av)) - longint'($signed(bv)) - longint'({63'd0, bv_in});
    r.diff     = u[W-1:0];
    r.bout     = u[W];
    r.overflow = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, score the transfers after it.
  task automatic cycle();
    result_t seen;
    result_t want;
    result_t got;
    logic    con;
    logic    rst_s;
    #1;
    last_in_ready = in_ready;
    last_acc      = in_valid && in_ready;
    con           = out_valid && out_ready;
    rst_s         = rst_n;
    seen.diff     = diff;
    seen.bout     = bout;
    seen.overflow = overflow;
    want          = model(a, b, bin);
    @(posedge clk);
    #1;
    if (con) begin
      n_consumed++;
      chk("output_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk("stream_diff", 64'(seen.diff), 64'(got.diff));
        chk("stream_bout", 64'(seen.bout), 64'(got.bout));
        chk("stream_ovf", 64'(seen.overflow), 64'(got.overflow));
      end
    end
    if (last_acc && rst_s) exp_q.push_back(want);
  endtask

  task automatic drain(output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 20) begin
      cycle();
      cycles++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic bv_in, input logic [W-1:0] ed, input logic eb,
                         input logic eo);
    a = av; b = bv; bin = bv_in; in_valid = 1'b1;
    cycle();
    chk({tag, "_accept"}, 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    chk({tag, "_not_yet_valid"}, 64'(out_valid), 64'd0);
    cycle();
    chk({tag, "_valid_at_2"}, 64'(out_valid), 64'd1);
    chk({tag, "_diff"}, 64'(diff), 64'(ed));
    chk({tag, "_bout"}, 64'(bout), 64'(eb));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int      dc;
    int      base;
    result_t hold;

    rst_n = 1'b0; out_ready = 1'b1;
    repeat (2) cycle();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_diff", 64'(diff), 64'd0);
    chk("reset_bout", 64'(bout), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    run_one("sub5_3", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    run_one("zero_minus1", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_one("min_minus1", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_one("bypass_all", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_one("both_flags", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
    drain(dc);

    // Full-rate random stream: in_ready never drops and the tail drains in 2 cycles.
    base = n_consumed;
    for (int i = 0; i < 8; i++) begin
      a = $urandom(); b = $urandom(); bin = 1'($urandom_range(1)); in_valid = 1'b1;
      cycle();
      chk("stream_in_ready", 64'(last_in_ready), 64'd1);
    end
    in_valid = 1'b0;
    drain(dc);
    chk("stream_tail_cycles", 64'(dc), 64'd2);
    chk("stream_count", 64'(n_consumed - base), 64'd8);

    // Backpressure: two accepted, third blocked, outputs hold the oldest result.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = $urandom(); b = $urandom(); bin = 1'($urandom_range(1)); in_valid = 1'b1;
      cycle();
      chk("stall_accept", 64'(last_acc), 64'd1);
    end
    a = $urandom(); b = $urandom(); bin = 1'($urandom_range(1));
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("stall_in_ready", 64'(last_in_ready), 64'd0);
      chk("stall_no_accept", 64'(last_acc), 64'd0);
      hold = exp_q[0];
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_hold_diff", 64'(diff), 64'(hold.diff));
      chk("stall_hold_bout", 64'(bout), 64'(hold.bout));
      chk("stall_hold_ovf", 64'(overflow), 64'(hold.overflow));
    end
    out_ready = 1'b1;
    cycle();
    chk("release_accept", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    drain(dc);

    // Reset with two results in flight: both must vanish.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a = $urandom(); b = $urandom(); bin = 1'($urandom_range(1)); in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0; rst_n = 1'b0;
    cycle();
    exp_q.delete();
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_diff", 64'(diff), 64'd0);
    chk("midreset_bout", 64'(bout), 64'd0);
    chk("midreset_ovf", 64'(overflow), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("post_reset_no_output", 64'(out_valid), 64'd0);
      chk("post_reset_in_ready", 64'(last_in_ready), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/borrow_bypass_subtractor_pipe.md
Name: borrow_bypass_subtractor_pipe

Overview:
- Two-stage pipelined 32-bit subtractor: diff = a - b - bin, using 4-bit borrow-bypass groups.
- It is the subtract-direction counterpart of the team's combinational carry-bypass adder.
- Sits in the ALU datapath behind a valid/ready handshake, so the slow borrow chain is split across two clock cycles.
- Reports borrow-out (unsigned a < b + bin) and signed overflow.

Parameters:
- WIDTH, 32, operand width; must be a multiple of 2*GROUP_W.
- GROUP_W, 4, bits per borrow-bypass group.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
- bout  output  1  borrow out; 1 iff unsigned a < b + bin.
- overflow  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Behaviour:
- Reset is sampled only at the clk edge while rst_n=0.
  - On reset, both stage valid flags clear and all data registers clear to 0.
  - Outputs after reset: out_valid=0, diff=0, bout=0, overflow=0. in_ready=1 in the first cycle after reset is released.
  - A reset mid-operation discards every in-flight result; nothing is emitted afterwards.
- Group logic, per group of GROUP_W bits:
  - Per bit: d_i = a_i ^ b_i ^ br_i and br_(i+1) = (~a_i & b_i) | (~(a_i ^ b_i) & br_i).
  - Group propagate = AND over bits of ~(a_i ^ b_i), i.e. all bits equal.
  - Group borrow out = propagate ? group borrow in : ripple borrow out, selected by a 2:1 mux.
- Stage 1, lower WIDTH/2 bits:
  - Computes the low half of diff and the mid borrow from a, b, bin.
  - Registers the low diff, mid borrow, a[upper half] and b[upper half], and sets s1_valid.
- Stage 2, upper WIDTH/2 bits:
  - Uses the registered upper operands with the registered mid borrow as its borrow in.
  - Registers the full diff, bout and overflow, and sets s2_valid.
  - out_valid = s2_valid.
- Latency: a result appears on the outputs exactly 2 cycles after its input handshake, given no backpressure. Throughput is 1 per cycle.
- Handshake:
  - An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
  - Stage 2 loads when (!s2_valid || out_ready).
  - Stage 1 advances into stage 2 under that same condition.
  - in_ready = !s1_valid || stage-2-load-condition. It is combinational and must not depend on in_valid.
  - While out_valid && !out_ready, diff, bout and overflow hold stable.
  - At most 2 results are in flight. No result is ever dropped or duplicated, and ordering is preserved.
- Simultaneous events: an output consume, a stage 1→2 move and a new input accept may all occur in the same cycle. Full-rate streaming must sustain 1 result per cycle.
- in_valid=0 leaves stage contents untouched. Bubbles propagate with their valid flag cleared; data registers may hold stale values.
- Wrap-around: diff is modulo 2^WIDTH. bout and overflow are independent flags; either, both or neither may be set.

Decomposition:
- Shared ALU package holds:
  - constants DEFAULT_WIDTH=32 and DEFAULT_GROUP_W=4;
  - a struct result_t {diff, bout, overflow} reused by the adder/subtractor consumers.
- One natural sub-module: borrow_bypass_group (GROUP_W-bit ripple borrow plus propagate-select mux).
  - It is instantiated WIDTH/GROUP_W/2 times per stage via generate.

Test Plan:
- a=5, b=3, bin=0 → diff=0x00000002, bout=0, overflow=0, out_valid exactly 2 cycles after accept.
- a=0, b=1, bin=0 → diff=0xFFFFFFFF, bout=1, overflow=0. Then a=0x80000000, b=1 → diff=0x7FFFFFFF, bout=0, overflow=1.
- a=b=0x12345678, bin=1 (every group bypasses, borrow crosses the stage boundary) → diff=0xFFFFFFFF, bout=1, overflow=0.
  - a=0x7FFFFFFF, b=0xFFFFFFFF, bin=0 → diff=0x80000000, bout=1, overflow=1.
- Back-to-back stream of 8 random operand sets with out_ready=1 → 8 consecutive results matching the reference model in order; in_ready stays 1.
- out_ready=0 for 4 cycles while 3 inputs are offered:
  - first 2 are accepted, then in_ready=0 and outputs are held stable;
  - out_ready then goes to 1 → results emitted in order, third input accepted the same cycle the stall releases.
- Reset asserted for 1 cycle with 2 results in flight → out_valid=0 the next cycle, all outputs 0, no stale result ever appears; in_ready=1 after reset release.
